branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the RISC-V fetch stage; supersedes static BEQ/BNE/BLT/BGE/BLTU/BGEU resolution-only handling.
- Holds a pattern history table (PHT) of saturating counters plus a tagless target table, indexed by bimodal or gshare hashing, selected by parameter.
- Fetch queries it with the PC. EX sends back the resolved outcome for every BRANCH-opcode instruction.

Parameters:
- PROGRAM_ADDRESS_WIDTH, 6 (package constant): width of word-addressed PC and targets.
- INDEX_BITS, 4: table depth is 2**INDEX_BITS entries; must be <= PROGRAM_ADDRESS_WIDTH.
- CTR_BITS, 2: saturating counter width, 1..4.
- GHR_BITS, 0: global history length; 0 selects bimodal, otherwise gshare; must be <= INDEX_BITS.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset (asserts on RESET = 1'b0).
- pred_valid_i, in, 1: lookup request.
- pred_pc_i, in, PROGRAM_ADDRESS_WIDTH: PC of the lookup.
- pred_valid_o, out, 1: prediction valid, one cycle after the request.
- pred_taken_o, out, 1: predicted taken.
- pred_target_o, out, PROGRAM_ADDRESS_WIDTH: predicted target.
- pred_ghr_o, out, max(GHR_BITS,1): GHR snapshot used for the lookup; the pipeline carries it to EX.
- upd_valid_i, in, 1: resolved branch from EX.
- upd_pc_i, in, PROGRAM_ADDRESS_WIDTH: PC of the resolved branch.
- upd_taken_i, in, 1: actual outcome.
- upd_target_i, in, PROGRAM_ADDRESS_WIDTH: actual target; ignored if not taken.
- upd_ghr_i, in, max(GHR_BITS,1): snapshot returned with the branch.
- upd_mispredict_i, in, 1: EX detected a direction or target mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - All counters set to weakly-not-taken, 2**(CTR_BITS-1)-1.
  - All target valid bits and targets cleared to 0.
  - GHR cleared to 0.
  - pred_valid_o, pred_taken_o, pred_target_o and pred_ghr_o cleared to 0.
  - Reset mid-operation discards all in-flight lookups.
- Indexing:
  - Lookup index = pred_pc_i[INDEX_BITS-1:0] XOR zero-extended GHR.
  - Update index = upd_pc_i[INDEX_BITS-1:0] XOR zero-extended upd_ghr_i.
  - When GHR_BITS=0, the XOR term is 0 and pred_ghr_o is tied to 0.
- Lookup latency: 1 cycle, with registered outputs.
  - pred_valid_o = pred_valid_i delayed one cycle.
  - pred_taken_o = counter MSB AND target-valid bit.
  - pred_target_o = stored target, or 0 if the valid bit is clear.
  - With pred_valid_i=0, pred_valid_o=0 and the other outputs hold their last values.
- Counter update on upd_valid_i:
  - Taken increments, saturating at 2**CTR_BITS-1; not-taken decrements, saturating at 0. No wrap in either direction.
  - If taken, the target is written and the valid bit set. If not taken, the target and valid bit are unchanged.
- Read/write collision: a lookup and an update to the same index in the same cycle returns the pre-update (old) entry. The update takes effect at that edge.
- GHR (GHR_BITS>0):
  - On pred_valid_i, GHR <= {GHR[GHR_BITS-2:0], predicted_taken}, where predicted_taken is the combinational value for this lookup (speculative).
  - On upd_valid_i && upd_mispredict_i, GHR <= {upd_ghr_i[GHR_BITS-2:0], upd_taken_i}. This restore has priority over a simultaneous lookup shift.
  - For GHR_BITS=1, the shift reduces to GHR <= bit.
  - upd_valid_i without upd_mispredict_i leaves the GHR untouched.
- No handshake back-pressure: the block accepts one lookup and one update every cycle.
- Non-branch opcodes must never drive upd_valid_i. This is the caller's responsibility; the assertion lives in the bench.

Decomposition:
- Shared package common additions:
  - BP_INDEX_BITS, BP_CTR_BITS and BP_GHR_BITS default constants.
  - bp_update_t packed struct {valid, pc, taken, target, ghr, mispredict}.
  - A function sat_inc_dec(ctr, taken) for saturating counter arithmetic.
- Reuse the existing BRANCH opcode and branch_type enum in the EX-side caller. PROGRAM_ADDRESS_WIDTH comes from the package.
- One natural sub-module, bp_table: a 2**INDEX_BITS array of {counter, valid, target} with one registered read port, one write port, async reset, and old-data-on-collision semantics.
- GHR logic and output registers stay in branch_predictor.

Test Plan:
- Reset check: INDEX_BITS=4, CTR_BITS=2, GHR_BITS=0; release reset, look up pc=6'h05 -> next cycle pred_valid_o=1, pred_taken_o=0, pred_target_o=0.
- Training: two updates pc=5 taken, target=6'h20 -> counter 01→10→11; lookup pc=5 -> pred_taken_o=1, pred_target_o=6'h20.
- Saturation: four further taken updates at pc=5 -> counter stays 11. Then three not-taken -> 00, and one more not-taken -> still 00; lookup -> pred_taken_o=0, pred_target_o=6'h20 (valid retained).
- Collision: same cycle, update pc=3 taken (counter 01→10) with lookup pc=3 -> pred_taken_o=0 (old). Lookup pc=3 the next cycle -> pred_taken_o=1.
- Gshare restore: GHR_BITS=4; three lookups predicted not-taken -> GHR=0000. Then update with upd_ghr_i=4'b0101, taken, mispredict, concurrent with a lookup -> GHR=4'b1011; the next pred_ghr_o equals 4'b1011.
- Async reset mid-stream: drop rst_n between edges while pred_valid_i=1 -> outputs go to 0 immediately; all counters read back weakly-not-taken after release.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor and its EX-side caller.
package branch_predictor_pkg;

   localparam int PROGRAM_ADDRESS_WIDTH = 6;

   // Default predictor geometry
   localparam int BP_INDEX_BITS = 4;
   localparam int BP_CTR_BITS   = 2;
   localparam int BP_GHR_BITS   = 0;

   // RV32 BRANCH major opcode and the funct3 encodings of the conditional branches
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } branch_type_t;

   // Resolved-branch bundle; ghr is held at full address width, zero-extended
   typedef struct packed {
      logic                             valid;
      logic [PROGRAM_ADDRESS_WIDTH-1:0] pc;
      logic                             taken;
      logic [PROGRAM_ADDRESS_WIDTH-1:0] target;
      logic [PROGRAM_ADDRESS_WIDTH-1:0] ghr;
      logic                             mispredict;
   } bp_update_t;

   // Saturating up/down step of a counter of ctr_bits (1..4) width
   function automatic logic [3:0] sat_inc_dec(input logic [3:0] ctr,
                                              input logic       taken,
                                              input logic [2:0] ctr_bits);
      logic [4:0] ctr_max;
      logic [3:0] res;
      ctr_max = (5'd1 << ctr_bits) - 5'd1;
      if (taken) begin
         if (ctr >= ctr_max[3:0]) res = ctr_max[3:0];
         else                     res = ctr + 4'd1;
      end else begin
         if (ctr == 4'd0) res = 4'd0;
         else             res = ctr - 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// Pattern history / target table: flop array of {counter, valid, target}.
// Reads see the stored contents, so a same-cycle write is not visible until
// after the edge (old data on collision).
module bp_table
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int CTR_BITS   = BP_CTR_BITS
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [INDEX_BITS-1:0]            rd_idx_i,
   output logic [CTR_BITS-1:0]              rd_ctr_o,
   output logic                             rd_valid_o,
   output logic [PROGRAM_ADDRESS_WIDTH-1:0] rd_target_o,
   input  logic                             wr_en_i,
   input  logic [INDEX_BITS-1:0]            wr_idx_i,
   input  logic                             wr_taken_i,
   input  logic [PROGRAM_ADDRESS_WIDTH-1:0] wr_target_i
);

   localparam int DEPTH = 2 ** INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   logic [CTR_BITS-1:0]              ctr_q    [DEPTH];
   logic                             valid_q  [DEPTH];
   logic [PROGRAM_ADDRESS_WIDTH-1:0] target_q [DEPTH];
   logic [CTR_BITS-1:0]              ctr_d;

   assign rd_ctr_o    = ctr_q[rd_idx_i];
   assign rd_valid_o  = valid_q[rd_idx_i];
   assign rd_target_o = target_q[rd_idx_i];

   // Next counter value for the entry being written
   always_comb begin
      ctr_d = CTR_BITS'(sat_inc_dec(4'(ctr_q[wr_idx_i]), wr_taken_i, 3'(CTR_BITS)));
   end

   // Entry storage: counters always step, target/valid only written on taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i]    <= CTR_WNT;
            valid_q[i]  <= 1'b0;
            target_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         ctr_q[wr_idx_i] <= ctr_d;
         if (wr_taken_i) begin
            valid_q[wr_idx_i]  <= 1'b1;
            target_q[wr_idx_i] <= wr_target_i;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: bimodal (GHR_BITS=0) or gshare indexing into a
// counter/target table, one-cycle registered lookup, speculative GHR with
// restore on mispredict.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter  int INDEX_BITS = BP_INDEX_BITS,
   parameter  int CTR_BITS   = BP_CTR_BITS,
   parameter  int GHR_BITS   = BP_GHR_BITS,
   localparam int GHR_W      = (GHR_BITS > 0) ? GHR_BITS : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             pred_valid_i,
   input  logic [PROGRAM_ADDRESS_WIDTH-1:0] pred_pc_i,
   output logic                             pred_valid_o,
   output logic                             pred_taken_o,
   output logic [PROGRAM_ADDRESS_WIDTH-1:0] pred_target_o,
   output logic [GHR_W-1:0]                 pred_ghr_o,
   input  logic                             upd_valid_i,
   input  logic [PROGRAM_ADDRESS_WIDTH-1:0] upd_pc_i,
   input  logic                             upd_taken_i,
   input  logic [PROGRAM_ADDRESS_WIDTH-1:0] upd_target_i,
   input  logic [GHR_W-1:0]                 upd_ghr_i,
   input  logic                             upd_mispredict_i
);

   localparam int AW = PROGRAM_ADDRESS_WIDTH;

   bp_update_t            upd_s;
   logic [GHR_W-1:0]      ghr_q, ghr_d;
   logic [INDEX_BITS-1:0] hist_s, rd_idx_s, wr_idx_s;
   logic [CTR_BITS-1:0]   rd_ctr_s;
   logic                  rd_valid_s;
   logic [AW-1:0]         rd_target_s;
   logic                  pred_taken_s;
   logic [AW-1:0]         pred_target_s;
   logic                  pred_valid_q, pred_taken_q;
   logic [AW-1:0]         pred_target_q;
   logic [GHR_W-1:0]      pred_ghr_q;
   logic                  unused_s;

   // Bundle the resolved branch; history is forced to zero in bimodal mode
   always_comb begin
      upd_s            = '0;
      upd_s.valid      = upd_valid_i;
      upd_s.pc         = upd_pc_i;
      upd_s.taken      = upd_taken_i;
      upd_s.target     = upd_target_i;
      upd_s.mispredict = upd_mispredict_i;
      if (GHR_BITS > 0) upd_s.ghr = AW'(upd_ghr_i);
      else              upd_s.ghr = '0;
   end

   // Table indices and the combinational prediction for this lookup
   always_comb begin
      if (GHR_BITS > 0) hist_s = INDEX_BITS'(ghr_q);
      else              hist_s = '0;
      rd_idx_s     = pred_pc_i[INDEX_BITS-1:0] ^ hist_s;
      wr_idx_s     = upd_s.pc[INDEX_BITS-1:0] ^ upd_s.ghr[INDEX_BITS-1:0];
      pred_taken_s = rd_ctr_s[CTR_BITS-1] & rd_valid_s;
      if (rd_valid_s) pred_target_s = rd_target_s;
      else            pred_target_s = '0;
   end

   bp_table #(
      .INDEX_BITS (INDEX_BITS),
      .CTR_BITS   (CTR_BITS)
   ) u_table (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx_i    (rd_idx_s),
      .rd_ctr_o    (rd_ctr_s),
      .rd_valid_o  (rd_valid_s),
      .rd_target_o (rd_target_s),
      .wr_en_i     (upd_s.valid),
      .wr_idx_i    (wr_idx_s),
      .wr_taken_i  (upd_s.taken),
      .wr_target_i (upd_s.target)
   );

   // GHR next state: mispredict restore beats the speculative lookup shift
   always_comb begin
      ghr_d = ghr_q;
      if (GHR_BITS > 0) begin
         if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = (upd_ghr_i << 1) | GHR_W'(upd_taken_i);
         end else if (pred_valid_i) begin
            ghr_d = (ghr_q << 1) | GHR_W'(pred_taken_s);
         end else begin
            ghr_d = ghr_q;
         end
      end else begin
         ghr_d = '0;
      end
   end

   // Global history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ghr_q <= '0;
      else        ghr_q <= ghr_d;
   end

   // Registered lookup results; hold the last prediction when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         pred_ghr_q    <= '0;
      end else if (pred_valid_i) begin
         pred_valid_q  <= 1'b1;
         pred_taken_q  <= pred_taken_s;
         pred_target_q <= pred_target_s;
         pred_ghr_q    <= ghr_q;
      end else begin
         pred_valid_q  <= 1'b0;
      end
   end

   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign pred_target_o = pred_target_q;
   assign pred_ghr_o    = pred_ghr_q;

   // PC bits above the index and unused history bits are intentionally dropped
   assign unused_s = ^{pred_pc_i, upd_pc_i, upd_ghr_i, upd_s};

endmodule
